// File: rtl/adv7513_reg_dump.sv
// ADV7513 register dump sequencer: walks first_addr..last_addr (with
// 8-bit wrap), issues one read per address and buffers {addr,data} pairs.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   go                    start a dump (sampled in IDLE only)
//   first_addr/last_addr  inclusive address range, latched on go
//   rd_start/rd_reg_addr  read request pulse and held address
//   rd_done/rd_data       read completion level and value
//   out_valid/out_ready   show-ahead buffer handshake
//   out_addr/out_data     head entry of the buffer
//   busy                  not in IDLE
//   dump_done             pulse after the last address is handled
//   timeout_err           sticky: a read timed out in this dump
module adv7513_reg_dump #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] first_addr,
    input  logic [7:0] last_addr,
    output logic       rd_start,
    output logic [7:0] rd_reg_addr,
    input  logic       rd_done,
    input  logic [7:0] rd_data,
    output logic       out_valid,
    output logic [7:0] out_addr,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       dump_done,
    output logic       timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_PUSH,
        S_NEXT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [7:0]    cur_addr;
    logic [7:0]    last_q;
    logic [7:0]    cap_data;
    logic          arm_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          done_q;
    logic          done_rise;
    logic          tmo_hit;
    logic          at_last;

    logic          push;
    logic          pop;
    logic          full;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [15:0]   mem [FIFO_DEPTH];

    // Only a fresh rising edge counts; a level left high by the
    // previous read is filtered by the two ARM cycles plus done_q.
    assign done_rise = rd_done & ~done_q;
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT));
    assign at_last   = (cur_addr == last_q);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (go) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                state_nx = S_ARM;
            end
            S_ARM: begin
                if (arm_cnt) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    state_nx = S_PUSH;
                end else if (tmo_hit) begin
                    state_nx = S_NEXT;
                end
            end
            S_PUSH: begin
                if (push) state_nx = S_NEXT;
            end
            S_NEXT: begin
                state_nx = at_last ? S_IDLE : S_ISSUE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        rd_start  = (state == S_ISSUE);
        busy      = (state != S_IDLE);
        dump_done = (state == S_NEXT) && at_last;
        // A pop in the same cycle frees a slot even when full.
        push      = (state == S_PUSH) && (!full || pop);
    end

    assign rd_reg_addr = cur_addr;

    // Sequencer datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr    <= 8'h00;
            last_q      <= 8'h00;
            cap_data    <= 8'h00;
            arm_cnt     <= 1'b0;
            tmo_cnt     <= '0;
            done_q      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done_q <= rd_done;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        cur_addr    <= first_addr;
                        last_q      <= last_addr;
                        timeout_err <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    arm_cnt <= 1'b0;
                end
                S_ARM: begin
                    arm_cnt <= ~arm_cnt;
                end
                S_WAIT: begin
                    if (done_rise) begin
                        cap_data <= rd_data;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_NEXT: begin
                    if (!at_last) cur_addr <= cur_addr + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Output buffer: pointers carry one extra wrap bit.
    assign out_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {cur_addr, cap_data};
    end

    assign {out_addr, out_data} = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_adv7513_reg_dump.sv
// Randomized bench for adv7513_reg_dump with a transaction-level
// model of issued addresses, buffered entries and the error flag.
module tb_adv7513_reg_dump;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic [7:0] first_addr = 8'h00;
    logic [7:0] last_addr = 8'h00;
    logic       rd_start;
    logic [7:0] rd_reg_addr;
    logic       rd_done;
    logic [7:0] rd_data;
    logic       out_valid;
    logic [7:0] out_addr;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       dump_done;
    logic       timeout_err;

    adv7513_reg_dump #(
        .FIFO_DEPTH(4),
        .TIMEOUT(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .go(go),
        .first_addr(first_addr),
        .last_addr(last_addr),
        .rd_start(rd_start),
        .rd_reg_addr(rd_reg_addr),
        .rd_done(rd_done),
        .rd_data(rd_data),
        .out_valid(out_valid),
        .out_addr(out_addr),
        .out_data(out_data),
        .out_ready(out_ready),
        .busy(busy),
        .dump_done(dump_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  regs [256];
    bit          dead [256];
    bit          stale = 0;
    int          fixed_lat = 0;
    int          rdy_mode = 1;

    logic [7:0]  exp_issue [$];
    logic [15:0] exp_ent [$];
    bit          exp_tmo = 0;
    logic [7:0]  issued_log [$];
    int          n_issue = 0;
    int          n_pop = 0;
    int          n_done = 0;
    logic [15:0] last_pop = '0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: got event, expected none/other", name);
    endtask

    // Read-stage model
    logic [7:0] rm_addr;
    int         rm_el;
    int         rm_lat;
    bit         rm_active = 0;
    bit         rm_stale = 0;

    initial begin
        rd_done = 1'b0;
        rd_data = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                rm_active = 0;
            end else if (rd_start) begin
                rm_addr = rd_reg_addr;
                rm_el = 0;
                rm_active = 1;
                rm_stale = stale;
                if (stale) begin
                    rd_done = 1'b1;
                    rd_data = ~regs[rm_addr];
                end else begin
                    rd_done = 1'b0;
                end
                if (dead[rm_addr]) rm_lat = -1;
                else if (fixed_lat != 0) rm_lat = fixed_lat;
                else if (stale) rm_lat = int'($urandom_range(5, 40));
                else rm_lat = int'($urandom_range(3, 40));
            end else if (rm_active) begin
                rm_el++;
                if (rm_stale && rm_el == 3) rd_done = 1'b0;
                if (rm_el == rm_lat) begin
                    chk("addr_held", {24'd0, rd_reg_addr}, {24'd0, rm_addr});
                    rd_done = 1'b1;
                    rd_data = regs[rm_addr];
                    rm_active = 0;
                end
            end
        end
    end

    // Consumer
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rd_start) begin
                    n_issue++;
                    issued_log.push_back(rd_reg_addr);
                    if (exp_issue.size() == 0) begin
                        fail("unexpected_rd_start");
                    end else begin
                        chk("issue_addr", {24'd0, rd_reg_addr},
                            {24'd0, exp_issue.pop_front()});
                    end
                end
                if (out_valid && out_ready) begin
                    n_pop++;
                    last_pop = {out_addr, out_data};
                    if (exp_ent.size() == 0) begin
                        fail("unexpected_entry");
                    end else begin
                        e = exp_ent.pop_front();
                        chk("entry", {16'd0, out_addr, out_data}, {16'd0, e});
                    end
                end
                if (dump_done) begin
                    n_done++;
                    chk("done_after_all_issued", exp_issue.size(), 0);
                end
            end
        end
    end

    task automatic start_dump(input logic [7:0] f, input logic [7:0] l);
        logic [7:0] a;
        bit any_dead;
        a = f;
        any_dead = 0;
        forever begin
            exp_issue.push_back(a);
            if (dead[a]) any_dead = 1;
            else exp_ent.push_back({a, regs[a]});
            if (a == l) break;
            a = a + 8'd1;
        end
        exp_tmo = any_dead;
        @(posedge clk);
        #1;
        go = 1'b1;
        first_addr = f;
        last_addr = l;
        @(posedge clk);
        #1;
        go = 1'b0;
        chk("tmo_clear_on_go", {31'd0, timeout_err}, 0);
        chk("busy_after_go", {31'd0, busy}, 1);
    endtask

    task automatic wait_done();
        int d0;
        bit seen;
        d0 = n_done;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (n_done > d0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            fail("dump_done_wait_expired");
        end else begin
            chk("timeout_err", {31'd0, timeout_err}, {31'd0, exp_tmo});
            @(negedge clk);
            chk("idle_after_done", {31'd0, busy}, 0);
            chk("single_done", n_done - d0, 1);
        end
    endtask

    task automatic drain();
        rdy_mode = 1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_ent.size() == 0) break;
        end
        chk("entries_left", exp_ent.size(), 0);
        @(negedge clk);
        chk("buffer_empty", {31'd0, out_valid}, 0);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int i0;
        int p0;
        logic [7:0] f;
        logic [7:0] l;
        logic [7:0] wrap_exp [4];
        for (int i = 0; i < 256; i++) begin
            regs[i] = 8'($urandom);
            dead[i] = 0;
        end
        regs[8'h42] = 8'hA5;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_start", {31'd0, rd_start}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_dump_done", {31'd0, dump_done}, 0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_rd_reg_addr", {24'd0, rd_reg_addr}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single read
        fixed_lat = 30;
        i0 = n_issue;
        p0 = n_pop;
        start_dump(8'h42, 8'h42);
        wait_done();
        drain();
        chk("single_issue_cnt", n_issue - i0, 1);
        chk("single_pop_cnt", n_pop - p0, 1);
        chk("single_entry", {16'd0, last_pop}, 32'h42A5);
        chk("single_tmo", {31'd0, timeout_err}, 0);
        fixed_lat = 0;

        // Range with back-pressure
        rdy_mode = 0;
        i0 = n_issue;
        p0 = n_pop;
        start_dump(8'h00, 8'h07);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (n_issue - i0 >= 5) break;
        end
        repeat (150) @(negedge clk);
        chk("stall_issue_cnt", n_issue - i0, 5);
        chk("stall_busy", {31'd0, busy}, 1);
        chk("stall_valid", {31'd0, out_valid}, 1);
        chk("stall_entries_pending", exp_ent.size(), 8);
        rdy_mode = 1;
        wait_done();
        drain();
        chk("bp_pop_cnt", n_pop - p0, 8);

        // Wrap-around
        rdy_mode = 2;
        i0 = issued_log.size();
        start_dump(8'hFE, 8'h01);
        wait_done();
        drain();
        wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        chk("wrap_cnt", issued_log.size() - i0, 4);
        for (int k = 0; k < 4; k++) begin
            if (i0 + k < issued_log.size()) begin
                chk("wrap_order", {24'd0, issued_log[i0 + k]},
                    {24'd0, wrap_exp[k]});
            end
        end

        // Timeout
        dead[8'h10] = 1;
        p0 = n_pop;
        start_dump(8'h0F, 8'h11);
        wait_done();
        chk("tmo_sticky", {31'd0, timeout_err}, 1);
        drain();
        chk("tmo_pop_cnt", n_pop - p0, 2);
        dead[8'h10] = 0;
        start_dump(8'h20, 8'h20);
        wait_done();
        drain();

        // Buffer survives a new go
        rdy_mode = 0;
        p0 = n_pop;
        start_dump(8'h30, 8'h31);
        wait_done();
        chk("kept_valid", {31'd0, out_valid}, 1);
        start_dump(8'h40, 8'h40);
        wait_done();
        drain();
        chk("kept_pop_cnt", n_pop - p0, 3);

        // Stale done level
        stale = 1;
        rdy_mode = 2;
        start_dump(8'h50, 8'h55);
        wait_done();
        drain();
        stale = 0;

        // Randomized dumps
        for (int r = 0; r < 12; r++) begin
            f = 8'($urandom);
            l = f + 8'($urandom_range(0, 6));
            for (int k = 0; k < 256; k++) dead[k] = 0;
            for (logic [7:0] a = f; ; a = a + 8'd1) begin
                if ($urandom_range(0, 7) == 0) dead[a] = 1;
                if (a == l) break;
            end
            stale = ($urandom_range(0, 2) == 0);
            rdy_mode = int'($urandom_range(1, 2));
            start_dump(f, l);
            wait_done();
            drain();
        end
        for (int k = 0; k < 256; k++) dead[k] = 0;
        stale = 0;

        // Reset during the third read
        fixed_lat = 40;
        rdy_mode = 0;
        i0 = n_issue;
        start_dump(8'h00, 8'h07);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (n_issue - i0 >= 3) break;
        end
        repeat (10) @(negedge clk);
        chk("pre_rst_valid", {31'd0, out_valid}, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 0);
        chk("async_rst_valid", {31'd0, out_valid}, 0);
        exp_issue.delete();
        exp_ent.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rdy_mode = 1;
        repeat (60) @(negedge clk);
        chk("rst_no_issue", n_issue - i0, 3);
        chk("rst_idle", {31'd0, busy}, 0);
        chk("rst_flushed", {31'd0, out_valid}, 0);
        fixed_lat = 0;
        start_dump(8'h60, 8'h61);
        wait_done();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/adv7513_reg_dump.md
ADV7513_REG_DUMP -- requirements
Module: adv7513_reg_dump

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, meaning the number of output buffer entries (power of two, 2..16).
REQ-002 The module SHALL have parameter TIMEOUT, default 65535, meaning the maximum number of cycles to wait for one register read to complete.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 go  input  1  single-cycle request to start a dump; sampled only in IDLE.
REQ-006 first_addr  input  8  first ADV7513 register address of the dump; latched on accepted go.
REQ-007 last_addr  input  8  last register address of the dump, inclusive; latched on accepted go.
REQ-008 rd_start  output  1  one-cycle pulse to the downstream register-read stage.
REQ-009 rd_reg_addr  output  8  register address presented to the read stage; held stable from rd_start until completion or timeout.
REQ-010 rd_done  input  1  level completion flag from the read stage.
REQ-011 rd_data  input  8  register value from the read stage; valid while rd_done is high.
REQ-012 out_valid  output  1  the buffer holds at least one entry.
REQ-013 out_addr  output  8  address of the head entry.
REQ-014 out_data  output  8  data of the head entry.
REQ-015 out_ready  input  1  consumer pops the head entry when out_valid and out_ready are both high.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 dump_done  output  1  one-cycle pulse when the last address has been handled.
REQ-018 timeout_err  output  1  sticky flag: at least one read timed out in the current dump.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, ARM, WAIT, PUSH and NEXT.
REQ-020 IDLE: go=1 SHALL latch first_addr/last_addr, set cur_addr=first_addr, clear timeout_err, and enter ISSUE; go in any other state SHALL be ignored.
REQ-021 ISSUE: the module SHALL drive rd_start=1 for exactly one cycle with rd_reg_addr=cur_addr, clear the timeout counter, and enter ARM.
REQ-022 ARM: the module SHALL stay for exactly 2 cycles, ignoring rd_done, so that a stale level from the previous read is not taken; it then enters WAIT.
REQ-023 WAIT: the module SHALL register rd_done and detect its rising edge; on the edge it SHALL capture {cur_addr, rd_data} and enter PUSH.
REQ-024 WAIT timeout: when the counter reaches TIMEOUT without an edge, the module SHALL set timeout_err, push no entry, and enter NEXT.
REQ-025 PUSH: if the buffer is not full, the module SHALL write the captured entry and enter NEXT; if the buffer is full, it SHALL stall in PUSH with the entry held.
REQ-026 NEXT: if cur_addr==last_addr, the module SHALL pulse dump_done and enter IDLE; otherwise it SHALL increment cur_addr modulo 256 and enter ISSUE.
REQ-027 Wrap-around: last_addr<first_addr SHALL dump first_addr..0xFF followed by 0x00..last_addr; first_addr==last_addr SHALL dump exactly one register.
REQ-028 Buffer: the FIFO SHALL be first-in first-out with show-ahead behaviour, so out_addr/out_data reflect the head combinationally from storage.
REQ-029 Buffer: a simultaneous push and pop SHALL be legal in any state, including full; count SHALL change by push minus pop.
REQ-030 Buffer: the FIFO SHALL use wrap-around pointers one bit wider than log2(FIFO_DEPTH).
REQ-031 Draining: entries SHALL remain poppable after the dump ends; a new go SHALL NOT flush the buffer.
REQ-032 Latency: the first entry SHALL become visible on out_valid 1 cycle after the PUSH write.

Reset
REQ-033 On reset high, the module SHALL immediately and asynchronously enter IDLE and clear rd_start, busy, dump_done, timeout_err, out_valid, the FIFO pointers and the counters.
REQ-034 On reset, rd_reg_addr SHALL be 0x00.
REQ-035 Reset asserted mid-dump SHALL abandon the dump without completing the in-flight read and SHALL discard all buffered entries.

Verification
REQ-036 Single read: first=last=0x42, read model returns 0xA5 after 30 cycles, out_ready=1 -> exactly one rd_start with addr 0x42, one entry {0x42,0xA5}, one dump_done pulse, timeout_err=0.
REQ-037 Range with back-pressure: first=0x00, last=0x07, out_ready=0 until dump stalls -> exactly 4 entries buffered and the FSM stalled in PUSH; releasing out_ready -> all 8 entries in order 0x00..0x07 with no loss or duplication.
REQ-038 Wrap: first=0xFE, last=0x01 -> addresses issued in order 0xFE, 0xFF, 0x00, 0x01, then dump_done.
REQ-039 Timeout: TIMEOUT=100, model never completes address 0x10 in range 0x0F..0x11 -> timeout_err=1, entries only for 0x0F and 0x11, and the next go clears timeout_err.
REQ-040 Stale done: model holds rd_done high continuously between reads -> no entry captured without a fresh rising edge after ARM.
REQ-041 Reset mid-WAIT: assert reset during the third read of 0x00..0x07 -> busy=0, out_valid=0 and no rd_start pulse until the next go.
